// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - E-stage multiply/divide controller owning HI/LO with modelled latency
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        md_hazard,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);

  state_t      state;
  logic [3:0]  count;
  logic [31:0] pending_hi, pending_lo;
  logic        pending_ok;

  logic        is_signed, a_neg, b_neg;
  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, divisor, uq, ur, q_res, r_res;

  // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly.
  always_comb begin
    is_signed = ~md_op[0];
    a_neg     = is_signed & A[31];
    b_neg     = is_signed & B[31];
    prod      = {{32{a_neg}}, A} * {{32{b_neg}}, B};
    a_mag     = a_neg ? (32'd0 - A) : A;
    b_mag     = b_neg ? (32'd0 - B) : B;
    divisor   = (B == 32'd0) ? 32'd1 : b_mag;
    uq        = a_mag / divisor;
    ur        = a_mag % divisor;
    q_res     = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    r_res     = a_neg ? (32'd0 - ur) : ur;
  end

  assign md_hazard = busy | (start & ~md_op[2]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= 4'd0;
      busy       <= 1'b0;
      HI         <= 32'd0;
      LO         <= 32'd0;
      pending_hi <= 32'd0;
      pending_lo <= 32'd0;
      pending_ok <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (md_op)
              3'd0, 3'd1: begin
                pending_hi <= prod[63:32];
                pending_lo <= prod[31:0];
                pending_ok <= 1'b1;
                count      <= MC;
                state      <= RUN;
                busy       <= 1'b1;
              end
              3'd2, 3'd3: begin
                pending_hi <= r_res;
                pending_lo <= q_res;
                pending_ok <= (B != 32'd0);
                count      <= DC;
                state      <= RUN;
                busy       <= 1'b1;
              end
              3'd4:    HI <= A;
              3'd5:    LO <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            if (pending_ok) begin
              HI <= pending_hi;
              LO <= pending_lo;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed vector bench for mdu_ctrl
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A, B;
  logic        busy, md_hazard;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .busy(busy), .md_hazard(md_hazard), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op at a negedge, count busy cycles (bounded), then check HI/LO.
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    @(negedge clk);
    start = 1'b1; md_op = v.op; A = v.a; B = v.b;
    #1;
    check($sformatf("hazard_start[%0d]", idx), {31'd0, md_hazard}, {31'd0, ~v.op[2]});
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      check($sformatf("hazard_busy[%0d]", idx), {31'd0, md_hazard}, 32'd1);
      n++;
      @(negedge clk);
    end
    check($sformatf("cycles[%0d]", idx), n, v.cyc);
    check($sformatf("hi[%0d]", idx), HI, v.hi);
    check($sformatf("lo[%0d]", idx), LO, v.lo);
  endtask

  initial begin
    int n;
    vec_t pre;

    vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{3'd3, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
    vecs[4]  = '{3'd4, 32'h12345678, 32'd0,        32'h12345678, 32'h00000003, 0};
    vecs[5]  = '{3'd5, 32'h00000009, 32'd0,        32'h12345678, 32'h00000009, 0};
    vecs[6]  = '{3'd4, 32'h000000AA, 32'd0,        32'h000000AA, 32'h00000009, 0};
    vecs[7]  = '{3'd5, 32'h000000BB, 32'd0,        32'h000000AA, 32'h000000BB, 0};
    vecs[8]  = '{3'd2, 32'd5,        32'd0,        32'h000000AA, 32'h000000BB, 10};
    vecs[9]  = '{3'd3, 32'd5,        32'd0,        32'h000000AA, 32'h000000BB, 10};
    vecs[10] = '{3'd6, 32'd5,        32'd3,        32'h000000AA, 32'h000000BB, 0};
    vecs[11] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[12] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[13] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[14] = '{3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[15] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[16] = '{3'd7, 32'h11111111, 32'd1,        32'hFFFFFFFE, 32'h00000001, 0};

    reset = 1'b0; start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0;
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hazard", {31'd0, md_hazard}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

    // MULT with an intruding MTLO mid-run and an MTHI on the final busy cycle.
    @(negedge clk);
    start = 1'b1; md_op = 3'd0; A = 32'd6; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      check("hazard_intrude", {31'd0, md_hazard}, 32'd1);
      start = (n == 1) || (n == 4);
      md_op = (n == 4) ? 3'd4 : 3'd5;
      A     = 32'h0000DEAD;
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    check("intrude_cycles", n, 5);
    check("intrude_hi", HI, 32'd0);
    check("intrude_lo", LO, 32'd42);

    pre = '{3'd4, 32'h00000055, 32'd0, 32'h00000055, 32'd42, 0};
    run_vec(pre, 100);

    // Asynchronous reset partway through a DIV.
    @(negedge clk);
    start = 1'b1; md_op = 3'd2; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_hi", HI, 32'd0);
    check("async_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    check("post_reset_hi", HI, 32'd0);
    check("post_reset_lo", LO, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
